// File: rtl/key_scan.sv
// key_scan: debounced reader for active-low push buttons.
//
// Each key runs through its own slice: a two-flop synchronizer, a stability
// counter that accepts a new level only after it has been held unchanged for
// DEBOUNCE_CYCLES synchronized cycles, and a hold counter that emits a single
// long-press pulse LONG_CYCLES cycles after the press is accepted.
//
// Parameters
//   NUM_KEYS         number of independent keys (1..8)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level (>= 2)
//   LONG_CYCLES      cycles after key_press before key_long fires (>= 1)
//
// Ports
//   clk          system clock
//   nrst         asynchronous active-low reset
//   key_n        raw key pins, asynchronous, 0 = pressed
//   key_level    debounced level, 1 = pressed
//   key_press    one-cycle pulse when an accepted level goes 0 -> 1
//   key_release  one-cycle pulse when an accepted level goes 1 -> 0
//   key_long     one-cycle pulse, at most once per press, after LONG_CYCLES held
//
// All outputs are registered; nothing reaches an output combinationally from
// key_n. Slices share no state, so simultaneous activity on several keys gives
// simultaneous, independent pulses.

module key_scan #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);

  // Last count value before a differing level is accepted.
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  // Hold counter: the step L_LAST -> L_MAX fires key_long, then it saturates.
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_CYCLES);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic          meta_q;     // first synchronizer stage
    logic          stable_q;   // second synchronizer stage, still active-low
    logic          sync;       // synchronized key, 1 = pressed
    logic [DW-1:0] dcnt;       // cycles the synchronized key has differed
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic [LW-1:0] lcnt;       // cycles held since the press was accepted
    logic          long_q;
    logic          accept;     // new level is accepted at this edge
    logic          release_now;

    // Both stages reset to the released state so a key held through reset is
    // seen as a fresh press once reset lifts.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        meta_q   <= 1'b1;
        stable_q <= 1'b1;
      end else begin
        meta_q   <= key_n[k];
        stable_q <= meta_q;
      end
    end

    assign sync        = ~stable_q;
    assign accept      = (sync != level_q) && (dcnt == D_LAST);
    assign release_now = accept && !sync;

    // Debounce: any cycle back at the current level throws away the count,
    // so only an unbroken run of DEBOUNCE_CYCLES differing cycles is accepted.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        dcnt      <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= accept && sync;
        release_q <= release_now;
        if (sync == level_q) begin
          dcnt <= '0;
        end else if (accept) begin
          level_q <= sync;
          dcnt    <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end

    // Long press: the counter is held at zero while released, which covers
    // the press edge itself (level is still 0 there), so counting starts on
    // the cycle after the press and key_long lands exactly LONG_CYCLES later.
    // A release accepted on the same edge suppresses the pulse.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        lcnt   <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= level_q && !release_now && (lcnt == L_LAST);
        if (!level_q || release_now) begin
          lcnt <= '0;
        end else if (lcnt < L_MAX) begin
          lcnt <= lcnt + 1'b1;
        end
      end
    end

    assign key_level[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_long[k]    = long_q;
  end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan with NUM_KEYS=4, DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
// Pulse expectations are queued with the edge number at which they must
// appear (edge 1 = first rising edge sampling the new raw level, pulses after
// edge 10) and a monitor compares every cycle that has either an expected or
// an observed pulse.

module tb_key_scan;

  localparam int NK = 4;
  localparam int DB = 8;
  localparam int LC = 32;
  localparam int LAT = DB + 2;
  localparam int W = 44;  // {edge[31:0], press[3:0], release[3:0], long[3:0]}

  logic          clk;
  logic          nrst;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  logic [W-1:0] exp_q[$];

  key_scan #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int edge_no, input logic [3:0] p,
                          input logic [3:0] r, input logic [3:0] l);
    logic [31:0] e;
    e = edge_no;
    exp_q.push_back({e, p, r, l});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [3:0] ep;
    logic [3:0] er;
    logic [3:0] el;
    logic [31:0] now;
    ep = '0;
    er = '0;
    el = '0;
    now = cyc;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][43:12] == now) begin
        ep = ep | exp_q[i][11:8];
        er = er | exp_q[i][7:4];
        el = el | exp_q[i][3:0];
        exp_q.delete(i);
      end
    end
    if (({ep, er, el} != 12'h000) || ({key_press, key_release, key_long} != 12'h000)) begin
      tests_run++;
      if ({key_press, key_release, key_long} !== {ep, er, el}) begin
        fails++;
        $display("FAIL pulses @edge %0d: press/release/long got %b/%b/%b expected %b/%b/%b",
                 now, key_press, key_release, key_long, ep, er, el);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset;
    nrst  = 1'b0;
    key_n = 4'b1110;
    repeat (20) begin
      @(negedge clk);
      tests_run++;
      if ({key_level, key_press, key_release, key_long} !== 16'h0000) begin
        fails++;
        $display("FAIL reset_outputs: got %h expected 0000",
                 {key_level, key_press, key_release, key_long});
      end
    end
    nrst = 1'b1;
    push_exp(cyc + LAT, 4'b0001, 4'b0000, 4'b0000);
    push_exp(cyc + LAT + LC, 4'b0000, 4'b0000, 4'b0001);
    tick(12);
    tests_run++;
    if (key_level !== 4'b0001) begin
      fails++;
      $display("FAIL reset_level: got %b expected 0001", key_level);
    end
    tick(35);
    key_n = 4'b1111;
    push_exp(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
    tick(14);
    tests_run++;
    if (key_level !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release_level: got %b expected 0000", key_level);
    end
  endtask

  task automatic test_press_release;
    key_n[1] = 1'b0;
    push_exp(cyc + LAT, 4'b0010, 4'b0000, 4'b0000);
    tick(20);
    tests_run++;
    if (key_level !== 4'b0010) begin
      fails++;
      $display("FAIL press_level: got %b expected 0010", key_level);
    end
    key_n[1] = 1'b1;
    push_exp(cyc + LAT, 4'b0000, 4'b0010, 4'b0000);
    tick(14);
    tests_run++;
    if (key_level !== 4'b0000) begin
      fails++;
      $display("FAIL release_level: got %b expected 0000", key_level);
    end
  endtask

  task automatic test_bounce;
    for (int p = 0; p < 10; p++) begin
      key_n[2] = p[0];
      tick(3);
    end
    key_n[2] = 1'b0;
    push_exp(cyc + LAT, 4'b0100, 4'b0000, 4'b0000);
    tick(20);
    tests_run++;
    if (key_level !== 4'b0100) begin
      fails++;
      $display("FAIL bounce_level: got %b expected 0100", key_level);
    end
    key_n[2] = 1'b1;
    push_exp(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
    tick(14);
  endtask

  task automatic test_glitch;
    key_n[3] = 1'b0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if (i == 6) key_n[3] = 1'b1;
      tests_run++;
      if (key_level !== 4'b0000) begin
        fails++;
        $display("FAIL glitch_level: got %b expected 0000", key_level);
      end
    end
  endtask

  task automatic test_long_press;
    key_n[0] = 1'b0;
    push_exp(cyc + LAT, 4'b0001, 4'b0000, 4'b0000);
    push_exp(cyc + LAT + LC, 4'b0000, 4'b0000, 4'b0001);
    tick(60);
    tests_run++;
    if (key_level !== 4'b0001) begin
      fails++;
      $display("FAIL long_level: got %b expected 0001", key_level);
    end
    key_n[0] = 1'b1;
    push_exp(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
    tick(14);
  endtask

  task automatic test_concurrent_reset;
    key_n = 4'b0110;
    push_exp(cyc + LAT, 4'b1001, 4'b0000, 4'b0000);
    tick(15);
    tests_run++;
    if (key_level !== 4'b1001) begin
      fails++;
      $display("FAIL concurrent_level: got %b expected 1001", key_level);
    end
    nrst = 1'b0;
    #1;
    tests_run++;
    if ({key_level, key_press, key_release, key_long} !== 16'h0000) begin
      fails++;
      $display("FAIL midreset_clear: got %h expected 0000",
               {key_level, key_press, key_release, key_long});
    end
    tick(2);
    nrst = 1'b1;
    push_exp(cyc + LAT, 4'b1001, 4'b0000, 4'b0000);
    tick(15);
    tests_run++;
    if (key_level !== 4'b1001) begin
      fails++;
      $display("FAIL repress_level: got %b expected 1001", key_level);
    end
    key_n = 4'b1111;
    push_exp(cyc + LAT, 4'b0000, 4'b1001, 4'b0000);
    tick(14);
  endtask

  task automatic test_back_to_back;
    int h;
    int g;
    for (int n = 0; n < 3; n++) begin
      h = $urandom_range(25, 12);
      g = $urandom_range(25, 12);
      key_n[1] = 1'b0;
      push_exp(cyc + LAT, 4'b0010, 4'b0000, 4'b0000);
      tick(h);
      key_n[1] = 1'b1;
      push_exp(cyc + LAT, 4'b0000, 4'b0010, 4'b0000);
      tick(g);
    end
    tick(4);
    tests_run++;
    if (key_level !== 4'b0000) begin
      fails++;
      $display("FAIL b2b_level: got %b expected 0000", key_level);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    nrst  = 1'b0;
    key_n = 4'b1110;
    test_reset();
    test_press_release();
    test_bounce();
    test_glitch();
    test_long_press();
    test_concurrent_reset();
    test_back_to_back();
    tick(5);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
